conv_viterbi_codec: RTL and testbench

- Rate-1/2, constraint-length-3 convolutional encoder (generators 7,5 octal) plus a matching hard-decision, 4-state Viterbi decoder.
- Survivor memory uses register exchange.
- Encoder and decoder are independent halves sharing clock and reset.
- The system bench places a bit-error-injecting channel register between encoder output and decoder input, and drives decoder enable from a one-cycle-delayed encoder valid.

---
 rtl/conv_viterbi_codec.sv | 124 ++++++++++++
 tb/tb_conv_viterbi_codec.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_viterbi_codec.sv
// Rate-1/2 K=3 (7,5) convolutional encoder plus 4-state hard-decision Viterbi decoder
// with register-exchange survivors. Define VITERBI_BEST_PM_EN to expose the best path metric.
module conv_viterbi_codec #(
    parameter int DEPTH = 16,
    parameter int PM_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enc_enable_i,
    input  logic            enc_d_i,
    output logic            enc_valid_o,
    output logic [1:0]      enc_d_o,
    input  logic            dec_enable_i,
    input  logic [1:0]      dec_d_i,
    output logic            dec_d_o,
    output logic            dec_valid_o
`ifdef VITERBI_BEST_PM_EN
    ,
    output logic [PM_W-1:0] dec_best_pm_o
`endif
);

    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [PM_W-1:0]  PM_INIT  = PM_W'(2 ** (PM_W - 3));

    // ---------------- encoder ----------------
    logic [1:0] enc_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_s       <= 2'b00;
            enc_d_o     <= 2'b00;
            enc_valid_o <= 1'b0;
        end else if (enc_enable_i) begin
            enc_d_o     <= {enc_d_i ^ enc_s[1] ^ enc_s[0], enc_d_i ^ enc_s[0]};
            enc_s       <= {enc_d_i, enc_s[1]};
            enc_valid_o <= 1'b1;
        end else begin
            enc_valid_o <= 1'b0;
        end
    end

    // ---------------- decoder ----------------
    function automatic logic [PM_W-1:0] branch_metric(input logic [1:0] rx,
                                                      input logic [1:0] pred,
                                                      input logic       b);
        logic [1:0] diff;
        diff = rx ^ {b ^ pred[1] ^ pred[0], b ^ pred[0]};
        return PM_W'(diff[1]) + PM_W'(diff[0]);
    endfunction

    logic [PM_W-1:0]  pm       [4];
    logic [PM_W-1:0]  pm_acs   [4];
    logic [PM_W-1:0]  pm_new   [4];
    logic [DEPTH-1:0] path     [4];
    logic [DEPTH-1:0] path_new [4];
    logic [CNT_W-1:0] cnt;
    logic             all_msb;
    logic [1:0]       best;
    logic [PM_W-1:0]  best_pm;

    for (genvar g = 0; g < 4; g++) begin : g_acs
        localparam logic [1:0] NS = 2'(g);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};
        logic [PM_W-1:0] cand0, cand1;
        logic            take1;

        assign cand0 = pm[P0] + branch_metric(dec_d_i, P0, NS[1]);
        assign cand1 = pm[P1] + branch_metric(dec_d_i, P1, NS[1]);
        // Strict compare: a tie keeps the predecessor whose s0 is 0.
        assign take1       = cand1 < cand0;
        assign pm_acs[g]   = take1 ? cand1 : cand0;
        assign path_new[g] = {take1 ? path[P1][DEPTH-2:0] : path[P0][DEPTH-2:0], NS[1]};
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        all_msb = 1'b1;
        best    = 2'd0;
        for (int i = 0; i < 4; i++) all_msb &= pm_acs[i][PM_W-1];
        for (int i = 0; i < 4; i++) pm_new[i] = all_msb ? {1'b0, pm_acs[i][PM_W-2:0]} : pm_acs[i];
        best_pm = pm_new[0];
        for (int i = 1; i < 4; i++) begin
            if (pm_new[i] < best_pm) begin
                best    = 2'(i);
                best_pm = pm_new[i];
            end
        end
    end

    // NOTE: survivor registers are plain flops, so they are reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= (i == 0) ? '0 : PM_INIT;
                path[i] <= '0;
            end
            cnt         <= '0;
            dec_d_o     <= 1'b0;
            dec_valid_o <= 1'b0;
`ifdef VITERBI_BEST_PM_EN
            dec_best_pm_o <= '0;
`endif
        end else if (dec_enable_i) begin
            for (int i = 0; i < 4; i++) begin
                pm[i]   <= pm_new[i];
                path[i] <= path_new[i];
            end
            cnt         <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
            dec_d_o     <= path_new[best][DEPTH-1];
            dec_valid_o <= (cnt >= CNT_LAST);
`ifdef VITERBI_BEST_PM_EN
            dec_best_pm_o <= best_pm;
`endif
        end else begin
            dec_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Directed bench for conv_viterbi_codec: encoder vectors, loopback through an error-injecting
// channel register, gaps, mid-stream reset and (with VITERBI_BEST_PM_EN) the best-metric port.
module tb_conv_viterbi_codec;

    localparam int DEPTH = 16;
    localparam int PM_W  = 8;
    localparam int NBITS = 256;

    logic            clk;
    logic            rst;
    logic            enc_enable_i;
    logic            enc_d_i;
    logic            enc_valid_o;
    logic [1:0]      enc_d_o;
    logic            dec_enable_i;
    logic [1:0]      dec_d_i;
    logic            dec_d_o;
    logic            dec_valid_o;
`ifdef VITERBI_BEST_PM_EN
    logic [PM_W-1:0] dec_best_pm_o;
`endif

    conv_viterbi_codec #(.DEPTH(DEPTH), .PM_W(PM_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_i      (enc_d_i),
        .enc_valid_o  (enc_valid_o),
        .enc_d_o      (enc_d_o),
        .dec_enable_i (dec_enable_i),
        .dec_d_i      (dec_d_i),
        .dec_d_o      (dec_d_o),
        .dec_valid_o  (dec_valid_o)
`ifdef VITERBI_BEST_PM_EN
        ,
        .dec_best_pm_o(dec_best_pm_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec;
    int   n_err;
    int   dec_syms;
    int   out_idx;
    int   err_mode;
    int   err_at;
    logic sent [$];
    logic bits [NBITS];

    // Channel: one register stage with optional bit0 inversion, valid delayed alongside.
    logic [1:0] chan_d;
    logic       chan_v;
    int         chan_sym;

    function automatic logic [1:0] inj_mask(input int sym);
        if (err_mode == 1 && (sym % 8) == 1) return 2'b01;
        if (err_mode == 2 && sym == err_at)  return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            chan_d   <= 2'b00;
            chan_v   <= 1'b0;
            chan_sym <= 0;
        end else begin
            chan_v <= enc_valid_o;
            if (enc_valid_o) begin
                chan_d   <= enc_d_o ^ inj_mask(chan_sym);
                chan_sym <= chan_sym + 1;
            end
        end
    end

    assign dec_enable_i = chan_v;
    assign dec_d_i      = chan_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock; the decoder model checks valid/latency and every decoded bit.
    task automatic step();
        logic en;
        en = dec_enable_i;
        @(posedge clk);
        #1;
        if (en) dec_syms++;
        check("dec_valid", dec_valid_o, en && (dec_syms >= DEPTH));
        if (dec_valid_o && out_idx < sent.size()) begin
            check("dec_bit", dec_d_o, sent[out_idx]);
            out_idx++;
        end
    endtask

    task automatic feed(input logic b);
        enc_enable_i = 1'b1;
        enc_d_i      = b;
        sent.push_back(b);
        step();
        enc_enable_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_enc_d", enc_d_o, 2'b00);
        check("rst_enc_v", enc_valid_o, 1'b0);
        check("rst_dec_d", dec_d_o, 1'b0);
        check("rst_dec_v", dec_valid_o, 1'b0);
        sent.delete();
        out_idx  = 0;
        dec_syms = 0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic run_stream(input int mode, input bit gaps);
        int n_idle;
        err_mode = mode;
        do_reset();
        for (int i = 0; i < NBITS; i++) begin
            n_idle = 0;
            while (gaps && n_idle < 8 && $urandom_range(0, 1) == 0) begin
                step();
                n_idle++;
            end
            feed(bits[i]);
        end
        idle(4);
        check("out_count", out_idx, NBITS - (DEPTH - 1));
    endtask

    logic       enc_bits [4];
    logic [1:0] enc_syms [4];

    initial begin
        n_vec        = 0;
        n_err        = 0;
        err_mode     = 0;
        err_at       = 0;
        dec_syms     = 0;
        out_idx      = 0;
        rst          = 1'b1;
        enc_enable_i = 1'b0;
        enc_d_i      = 1'b0;
        for (int i = 0; i < NBITS; i++) bits[i] = 1'($urandom_range(0, 1));

        // Encoder directed vectors: 1,0,1,1 -> 11,10,00,01
        enc_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
        enc_syms = '{2'b11, 2'b10, 2'b00, 2'b01};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            feed(enc_bits[i]);
            check("enc_sym", enc_d_o, enc_syms[i]);
            check("enc_valid", enc_valid_o, 1'b1);
        end
        step();
        check("enc_idle_v", enc_valid_o, 1'b0);
        check("enc_idle_d", enc_d_o, 2'b01);
        idle(3);

        // Loopback: clean, periodic errors, random gaps
        run_stream(0, 1'b0);
        run_stream(1, 1'b0);
        run_stream(0, 1'b1);

        // Mid-stream reset after 40 decoded symbols, then a fresh stream
        err_mode = 0;
        do_reset();
        for (int i = 0; i < NBITS && dec_syms < 40; i++) feed(bits[i]);
        check("mid_reach", dec_syms, 40);
        check("mid_pre_v", dec_valid_o, 1'b1);
        do_reset();
        for (int i = 0; i < 64; i++) feed(bits[NBITS - 1 - i]);
        idle(4);
        check("mid_count", out_idx, 64 - (DEPTH - 1));

`ifdef VITERBI_BEST_PM_EN
        // Best metric: zero on a clean all-zero stream, 1 shortly after one error
        err_mode = 2;
        err_at   = 20;
        do_reset();
        for (int i = 0; i < 64 && dec_syms < 20; i++) begin
            feed(1'b0);
            check("best_pm_clean", dec_best_pm_o, 0);
        end
        for (int i = 0; i < 64 && dec_syms < 23; i++) feed(1'b0);
        check("best_pm_err", dec_best_pm_o, 1);
        idle(3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
